// File: rtl/cb_bitop_if.sv
// Bus bundle for the CB-prefix BIT/RES/SET sequencer: request, operands, memory port and results.
interface cb_bitop_if;
  // Request handshake: start is sampled only while busy=0 (idle or the done clock).
  // Once accepted, busy stays high until the done clock, where a new start may be taken.
  logic       start;
  logic [7:0] opcode;
  logic [7:0] reg_in;
  logic [3:0] flags_in;
  logic [7:0] mem_rdata;

  logic       busy;
  logic       done;
  logic       illegal;
  logic [7:0] result;
  logic [3:0] flags_out;
  logic       reg_we;
  logic       mem_re;
  logic       mem_we;
  logic [7:0] mem_wdata;

  modport master (
    output start, opcode, reg_in, flags_in, mem_rdata,
    input  busy, done, illegal, result, flags_out, reg_we, mem_re, mem_we, mem_wdata
  );

  modport slave (
    input  start, opcode, reg_in, flags_in, mem_rdata,
    output busy, done, illegal, result, flags_out, reg_we, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/cb_bitop_seq.sv
// SM83 CB-page BIT/RES/SET executor on a register or (HL), sequenced in M-cycles of MCYCLE_CLKS clocks.
module cb_bitop_seq #(
  parameter int MCYCLE_CLKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  cb_bitop_if.slave  bus,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXEC     = 3'd1,
    S_MEM_RD   = 3'd2,
    S_MEM_CALC = 3'd3,
    S_MEM_WR   = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [1:0] OP_ILL = 2'b00;
  localparam logic [1:0] OP_BIT = 2'b01;
  localparam logic [1:0] OP_RES = 2'b10;
  localparam logic [1:0] OP_SET = 2'b11;

  // cnt_q tracks the clock index k of the running operation (k=1 on the first busy clock).
  localparam int CW = 6;
  localparam logic [CW-1:0] K_M1  = CW'(MCYCLE_CLKS - 1);
  localparam logic [CW-1:0] K_M   = CW'(MCYCLE_CLKS);
  localparam logic [CW-1:0] K_2M1 = CW'(2 * MCYCLE_CLKS - 1);
  localparam logic [CW-1:0] K_2M  = CW'(2 * MCYCLE_CLKS);
  localparam logic [CW-1:0] K_3M1 = CW'(3 * MCYCLE_CLKS - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [1:0]    op_q;
  logic [2:0]    bit_q;
  logic          hl_q;
  logic [3:0]    flags_q;
  logic [7:0]    operand_q;
  logic [7:0]    result_q;
  logic [3:0]    flags_out_q;
  logic [7:0]    wdata_q;

  logic          accept;
  logic          op_end;
  logic          rd_last;
  logic          req_illegal;
  logic          req_hl;

  function automatic logic [7:0] bit_apply(input logic [1:0] op, input logic [2:0] b,
                                           input logic [7:0] v);
    logic [7:0] mask;
    mask = 8'b1 << b;
    case (op)
      OP_RES:  bit_apply = v & ~mask;
      OP_SET:  bit_apply = v | mask;
      default: bit_apply = v;
    endcase
  endfunction

  // BIT replaces Z/N/H and keeps C; RES/SET leave all flags untouched.
  function automatic logic [3:0] flag_apply(input logic [1:0] op, input logic [2:0] b,
                                            input logic [7:0] v, input logic [3:0] f);
    if (op == OP_BIT) flag_apply = {~v[b], 1'b0, 1'b1, f[0]};
    else              flag_apply = f;
  endfunction

  assign accept      = bus.start && !reset && (state_q == S_IDLE || state_q == S_DONE);
  assign req_illegal = (bus.opcode[7:6] == OP_ILL);
  assign req_hl      = (bus.opcode[2:0] == 3'd6);
  assign rd_last     = (state_q == S_MEM_RD) && (cnt_q == K_M);
  assign op_end      = (state_d == S_DONE) &&
                       (state_q == S_EXEC || state_q == S_MEM_CALC || state_q == S_MEM_WR);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. An illegal opcode has nothing to execute, so it completes at k=1.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (req_illegal)  state_d = S_DONE;
          else if (req_hl)  state_d = S_MEM_RD;
          else              state_d = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC:     if (cnt_q == K_M1)  state_d = S_DONE;
      S_MEM_RD:   if (cnt_q == K_M)   state_d = (op_q == OP_BIT) ? S_MEM_CALC : S_MEM_WR;
      S_MEM_CALC: if (cnt_q == K_2M1) state_d = S_DONE;
      S_MEM_WR:   if (cnt_q == K_3M1) state_d = S_DONE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Datapath: operand latch, k counter, result/flag registers and write data.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      op_q        <= OP_ILL;
      bit_q       <= '0;
      hl_q        <= 1'b0;
      flags_q     <= '0;
      operand_q   <= '0;
      result_q    <= '0;
      flags_out_q <= '0;
      wdata_q     <= '0;
    end else begin
      if (accept) begin
        cnt_q     <= CW'(1);
        op_q      <= bus.opcode[7:6];
        bit_q     <= bus.opcode[5:3];
        hl_q      <= req_hl;
        flags_q   <= bus.flags_in;
        operand_q <= bus.reg_in;
        if (req_illegal) begin
          result_q    <= '0;
          flags_out_q <= bus.flags_in;
        end
      end else if (state_q == S_IDLE || state_q == S_DONE) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end

      // Memory operand arrives at the end of the read M-cycle; write data is fixed from then on.
      if (rd_last) begin
        operand_q <= bus.mem_rdata;
        if (op_q != OP_BIT) wdata_q <= bit_apply(op_q, bit_q, bus.mem_rdata);
      end

      if (op_end) begin
        result_q    <= bit_apply(op_q, bit_q, operand_q);
        flags_out_q <= flag_apply(op_q, bit_q, operand_q, flags_q);
      end
    end
  end

  // Output logic. Strobes are forced low while reset is held.
  always_comb begin
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.illegal = 1'b0;
    bus.reg_we  = 1'b0;
    bus.mem_re  = 1'b0;
    bus.mem_we  = 1'b0;
    if (!reset) begin
      case (state_q)
        S_EXEC, S_MEM_CALC: bus.busy = 1'b1;
        S_MEM_RD: begin
          bus.busy   = 1'b1;
          bus.mem_re = 1'b1;
        end
        S_MEM_WR: begin
          bus.busy   = 1'b1;
          bus.mem_we = (cnt_q > K_2M);
        end
        S_DONE: begin
          bus.done    = 1'b1;
          bus.illegal = (op_q == OP_ILL);
          bus.reg_we  = !hl_q && op_q[1];
          bus.mem_we  = hl_q && op_q[1];
        end
        default: ;
      endcase
    end
  end

  assign bus.result    = result_q;
  assign bus.flags_out = flags_out_q;
  assign bus.mem_wdata = wdata_q;
  assign fsm_state     = state_q;

endmodule
